// File: rtl/ez90_pkg.sv
// Shared eZ90 definitions used by the retire stage: renamed micro-op layout,
// register-file index widths and the commit-stage state encoding.
package ez90_pkg;

   localparam int EZ90_AREG_W = 5;
   localparam int EZ90_PREG_W = 6;

   typedef struct packed {
      logic [31:0]            pc;
      logic                   rd_valid;
      logic [EZ90_AREG_W-1:0] rd_arch;
      logic [EZ90_PREG_W-1:0] pd;
      logic [EZ90_PREG_W-1:0] pd_old;
   } ez90_uop_rn_t;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      TRAP
   } ez90_commit_state_e;

endpackage

// File: rtl/ez90_commit_if.sv
// ROB-head / retire / trap bundle between the eZ90 commit stage (slave) and
// the surrounding ROB, rename and CSR logic (master).
interface ez90_commit_if #(
   parameter int INSTRET_W = 64
);
   import ez90_pkg::*;

   logic                   commit_en;
   logic                   head_valid;
   logic                   head_done;
   ez90_uop_rn_t           head_uop;
   logic [5:0]             head_idx;
   logic                   head_has_trap;
   logic [31:0]            head_trap_cause;
   logic                   head_pop;
   logic                   flush;
   logic                   rat_wr_valid;
   logic [EZ90_AREG_W-1:0] rat_wr_arch;
   logic [EZ90_PREG_W-1:0] rat_wr_preg;
   logic                   free_valid;
   logic [EZ90_PREG_W-1:0] free_preg;
   logic                   retire_valid;
   logic [31:0]            retire_pc;
   logic                   trap_valid;
   logic [31:0]            trap_cause;
   logic [31:0]            trap_epc;
   logic                   trap_ready;
   logic [INSTRET_W-1:0]   instret;

   modport master (
      output commit_en, head_valid, head_done, head_uop, head_idx,
             head_has_trap, head_trap_cause, trap_ready,
      input  head_pop, flush, rat_wr_valid, rat_wr_arch, rat_wr_preg,
             free_valid, free_preg, retire_valid, retire_pc,
             trap_valid, trap_cause, trap_epc, instret
   );

   modport slave (
      input  commit_en, head_valid, head_done, head_uop, head_idx,
             head_has_trap, head_trap_cause, trap_ready,
      output head_pop, flush, rat_wr_valid, rat_wr_arch, rat_wr_preg,
             free_valid, free_preg, retire_valid, retire_pc,
             trap_valid, trap_cause, trap_epc, instret
   );

endinterface

// File: rtl/ez90_commit.sv
// In-order retire stage: pops completed ROB head entries, updates the
// architectural RAT and free list, and sequences flush + trap hand-off.
module ez90_commit
   import ez90_pkg::*;
#(
   parameter int INSTRET_W    = 64,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   ez90_commit_if.slave bus
);

   localparam logic [3:0]           FLUSH_CNT_INIT = 4'(FLUSH_CYCLES);
   localparam logic [INSTRET_W-1:0] INSTRET_ONE    = INSTRET_W'(1);

   ez90_commit_state_e     state_q, state_d;
   logic [3:0]             flush_cnt_q, flush_cnt_d;
   logic                   flush_q, flush_d;
   logic                   trap_valid_q, trap_valid_d;
   logic [31:0]            trap_cause_q, trap_cause_d;
   logic [31:0]            trap_epc_q, trap_epc_d;
   logic                   retire_valid_q, retire_valid_d;
   logic [31:0]            retire_pc_q, retire_pc_d;
   logic                   rat_wr_valid_q, rat_wr_valid_d;
   logic [EZ90_AREG_W-1:0] rat_wr_arch_q, rat_wr_arch_d;
   logic [EZ90_PREG_W-1:0] rat_wr_preg_q, rat_wr_preg_d;
   logic                   free_valid_q, free_valid_d;
   logic [EZ90_PREG_W-1:0] free_preg_q, free_preg_d;
   logic [INSTRET_W-1:0]   instret_q, instret_d;
   logic                   pop;
   logic                   unused_head_idx;

   // Pop decision is combinational so the ROB sees it in the same cycle.
   assign pop = rst_n && (state_q == RUN) && bus.commit_en
                && bus.head_valid && bus.head_done;
   assign unused_head_idx = ^bus.head_idx;

   always_comb begin
      state_d        = state_q;
      flush_cnt_d    = flush_cnt_q;
      flush_d        = 1'b0;
      trap_valid_d   = 1'b0;
      trap_cause_d   = trap_cause_q;
      trap_epc_d     = trap_epc_q;
      retire_valid_d = 1'b0;
      retire_pc_d    = retire_pc_q;
      rat_wr_valid_d = 1'b0;
      rat_wr_arch_d  = rat_wr_arch_q;
      rat_wr_preg_d  = rat_wr_preg_q;
      free_valid_d   = 1'b0;
      free_preg_d    = free_preg_q;
      instret_d      = instret_q;
      unique case (state_q)
         RUN: begin
            if (pop && bus.head_has_trap) begin
               trap_cause_d = bus.head_trap_cause;
               trap_epc_d   = bus.head_uop.pc;
               flush_cnt_d  = FLUSH_CNT_INIT;
               flush_d      = 1'b1;
               state_d      = FLUSH;
            end else if (pop) begin
               retire_valid_d = 1'b1;
               retire_pc_d    = bus.head_uop.pc;
               rat_wr_valid_d = bus.head_uop.rd_valid;
               rat_wr_arch_d  = bus.head_uop.rd_arch;
               rat_wr_preg_d  = bus.head_uop.pd;
               free_valid_d   = bus.head_uop.rd_valid;
               free_preg_d    = bus.head_uop.pd_old;
               instret_d      = instret_q + INSTRET_ONE;
            end
         end
         FLUSH: begin
            // The counter holds the number of flush cycles still to be shown,
            // including the current one.
            if (flush_cnt_q <= 4'd1) begin
               flush_cnt_d  = 4'd0;
               trap_valid_d = 1'b1;
               state_d      = TRAP;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
               flush_d     = 1'b1;
            end
         end
         TRAP: begin
            if (bus.trap_ready) begin
               state_d = RUN;
            end else begin
               trap_valid_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= RUN;
         flush_cnt_q    <= '0;
         flush_q        <= 1'b0;
         trap_valid_q   <= 1'b0;
         trap_cause_q   <= '0;
         trap_epc_q     <= '0;
         retire_valid_q <= 1'b0;
         retire_pc_q    <= '0;
         rat_wr_valid_q <= 1'b0;
         rat_wr_arch_q  <= '0;
         rat_wr_preg_q  <= '0;
         free_valid_q   <= 1'b0;
         free_preg_q    <= '0;
         instret_q      <= '0;
      end else begin
         state_q        <= state_d;
         flush_cnt_q    <= flush_cnt_d;
         flush_q        <= flush_d;
         trap_valid_q   <= trap_valid_d;
         trap_cause_q   <= trap_cause_d;
         trap_epc_q     <= trap_epc_d;
         retire_valid_q <= retire_valid_d;
         retire_pc_q    <= retire_pc_d;
         rat_wr_valid_q <= rat_wr_valid_d;
         rat_wr_arch_q  <= rat_wr_arch_d;
         rat_wr_preg_q  <= rat_wr_preg_d;
         free_valid_q   <= free_valid_d;
         free_preg_q    <= free_preg_d;
         instret_q      <= instret_d;
      end
   end

   assign bus.head_pop     = pop;
   assign bus.flush        = flush_q;
   assign bus.rat_wr_valid = rat_wr_valid_q;
   assign bus.rat_wr_arch  = rat_wr_arch_q;
   assign bus.rat_wr_preg  = rat_wr_preg_q;
   assign bus.free_valid   = free_valid_q;
   assign bus.free_preg    = free_preg_q;
   assign bus.retire_valid = retire_valid_q;
   assign bus.retire_pc    = retire_pc_q;
   assign bus.trap_valid   = trap_valid_q;
   assign bus.trap_cause   = trap_cause_q;
   assign bus.trap_epc     = trap_epc_q;
   assign bus.instret      = instret_q;

endmodule
